// File: rtl/axi_bus_dv.sv
// AXI4+ATOP pass-through bus stage with a passive protocol monitor.
// All channels connect straight through; the monitor counts handshakes and latches the first violation.
module axi_bus_dv #(
  parameter int unsigned AXI_ADDR_WIDTH = 48,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned LEN_FIFO_DEPTH = 8,
  localparam int unsigned AWW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 35,
  localparam int unsigned ARW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 29,
  localparam int unsigned WW  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1 + AXI_USER_WIDTH,
  localparam int unsigned BW  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH,
  localparam int unsigned RW  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           slv_aw_valid_i,
  input  logic [AWW-1:0] slv_aw_i,
  output logic           slv_aw_ready_o,
  input  logic           slv_w_valid_i,
  input  logic [WW-1:0]  slv_w_i,
  output logic           slv_w_ready_o,
  input  logic           slv_ar_valid_i,
  input  logic [ARW-1:0] slv_ar_i,
  output logic           slv_ar_ready_o,
  output logic           mst_aw_valid_o,
  output logic [AWW-1:0] mst_aw_o,
  input  logic           mst_aw_ready_i,
  output logic           mst_w_valid_o,
  output logic [WW-1:0]  mst_w_o,
  input  logic           mst_w_ready_i,
  output logic           mst_ar_valid_o,
  output logic [ARW-1:0] mst_ar_o,
  input  logic           mst_ar_ready_i,
  input  logic           mst_b_valid_i,
  input  logic [BW-1:0]  mst_b_i,
  output logic           mst_b_ready_o,
  input  logic           mst_r_valid_i,
  input  logic [RW-1:0]  mst_r_i,
  output logic           mst_r_ready_o,
  output logic           slv_b_valid_o,
  output logic [BW-1:0]  slv_b_o,
  input  logic           slv_b_ready_i,
  output logic           slv_r_valid_o,
  output logic [RW-1:0]  slv_r_o,
  input  logic           slv_r_ready_i,
  output logic [31:0]    aw_cnt_o,
  output logic [31:0]    w_cnt_o,
  output logic [31:0]    b_cnt_o,
  output logic [31:0]    ar_cnt_o,
  output logic [31:0]    r_cnt_o,
  output logic [15:0]    wr_outst_o,
  output logic [15:0]    rd_outst_o,
  output logic           proto_err_o,
  output logic [3:0]     err_code_o
);

  localparam int unsigned LEN_LSB = AXI_USER_WIDTH + 27;
  localparam int unsigned PW = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LEN_FIFO_DEPTH + 1);

  // Zero-latency data path
  assign mst_aw_valid_o = slv_aw_valid_i;
  assign mst_aw_o       = slv_aw_i;
  assign slv_aw_ready_o = mst_aw_ready_i;
  assign mst_w_valid_o  = slv_w_valid_i;
  assign mst_w_o        = slv_w_i;
  assign slv_w_ready_o  = mst_w_ready_i;
  assign mst_ar_valid_o = slv_ar_valid_i;
  assign mst_ar_o       = slv_ar_i;
  assign slv_ar_ready_o = mst_ar_ready_i;
  assign slv_b_valid_o  = mst_b_valid_i;
  assign slv_b_o        = mst_b_i;
  assign mst_b_ready_o  = slv_b_ready_i;
  assign slv_r_valid_o  = mst_r_valid_i;
  assign slv_r_o        = mst_r_i;
  assign mst_r_ready_o  = slv_r_ready_i;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, w_last, r_last;
  logic [7:0] aw_len;
  assign aw_hs  = slv_aw_valid_i & mst_aw_ready_i;
  assign w_hs   = slv_w_valid_i  & mst_w_ready_i;
  assign ar_hs  = slv_ar_valid_i & mst_ar_ready_i;
  assign b_hs   = mst_b_valid_i  & slv_b_ready_i;
  assign r_hs   = mst_r_valid_i  & slv_r_ready_i;
  assign w_last = slv_w_i[AXI_USER_WIDTH];
  assign r_last = mst_r_i[AXI_USER_WIDTH];
  assign aw_len = slv_aw_i[LEN_LSB +: 8];

  logic           aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q;
  logic [AWW-1:0] aw_pl_q;
  logic [WW-1:0]  w_pl_q;
  logic [BW-1:0]  b_pl_q;
  logic [ARW-1:0] ar_pl_q;
  logic [RW-1:0]  r_pl_q;

  logic [7:0]    fifo_mem [LEN_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [7:0]    beat_q;
  logic          fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CW'(LEN_FIFO_DEPTH));
  assign pop        = w_hs & w_last & ~fifo_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push       = aw_hs & (~fifo_full | pop);

  logic [9:1]  err;
  logic [3:0]  err_code_d;
  logic [15:0] wr_outst_d, rd_outst_d;
  logic        r_dec;
  assign r_dec = r_hs & r_last;

  always_comb begin
    err    = '0;
    err[1] = aw_stall_q & (~slv_aw_valid_i | (slv_aw_i != aw_pl_q));
    err[2] = w_stall_q  & (~slv_w_valid_i  | (slv_w_i  != w_pl_q));
    err[3] = b_stall_q  & (~mst_b_valid_i  | (mst_b_i  != b_pl_q));
    err[4] = ar_stall_q & (~slv_ar_valid_i | (slv_ar_i != ar_pl_q));
    err[5] = r_stall_q  & (~mst_r_valid_i  | (mst_r_i  != r_pl_q));
    err[6] = w_hs & ~fifo_empty & (w_last != (beat_q == fifo_mem[rd_ptr_q]));
    err[7] = b_hs & (wr_outst_o == '0);
    err[8] = r_dec & (rd_outst_o == '0);
    err[9] = aw_hs & fifo_full & ~pop;
    err_code_d = '0;
    for (int i = 9; i >= 1; i--) begin
      if (err[i]) err_code_d = 4'(i);
    end
  end

  // Outstanding counters: simultaneous inc/dec cancel, both ends saturate
  always_comb begin
    wr_outst_d = wr_outst_o;
    rd_outst_d = rd_outst_o;
    if (aw_hs && !b_hs && wr_outst_o != 16'hFFFF) wr_outst_d = wr_outst_o + 16'd1;
    else if (!aw_hs && b_hs && wr_outst_o != 16'h0) wr_outst_d = wr_outst_o - 16'd1;
    if (ar_hs && !r_dec && rd_outst_o != 16'hFFFF) rd_outst_d = rd_outst_o + 16'd1;
    else if (!ar_hs && r_dec && rd_outst_o != 16'h0) rd_outst_d = rd_outst_o - 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_cnt_o    <= '0;
      w_cnt_o     <= '0;
      b_cnt_o     <= '0;
      ar_cnt_o    <= '0;
      r_cnt_o     <= '0;
      wr_outst_o  <= '0;
      rd_outst_o  <= '0;
      proto_err_o <= 1'b0;
      err_code_o  <= '0;
      aw_stall_q  <= 1'b0;
      w_stall_q   <= 1'b0;
      b_stall_q   <= 1'b0;
      ar_stall_q  <= 1'b0;
      r_stall_q   <= 1'b0;
      aw_pl_q     <= '0;
      w_pl_q      <= '0;
      b_pl_q      <= '0;
      ar_pl_q     <= '0;
      r_pl_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      beat_q      <= '0;
      for (int i = 0; i < int'(LEN_FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      if (aw_hs) aw_cnt_o <= aw_cnt_o + 32'd1;
      if (w_hs)  w_cnt_o  <= w_cnt_o  + 32'd1;
      if (b_hs)  b_cnt_o  <= b_cnt_o  + 32'd1;
      if (ar_hs) ar_cnt_o <= ar_cnt_o + 32'd1;
      if (r_hs)  r_cnt_o  <= r_cnt_o  + 32'd1;
      wr_outst_o <= wr_outst_d;
      rd_outst_o <= rd_outst_d;

      aw_stall_q <= slv_aw_valid_i & ~mst_aw_ready_i;
      w_stall_q  <= slv_w_valid_i  & ~mst_w_ready_i;
      b_stall_q  <= mst_b_valid_i  & ~slv_b_ready_i;
      ar_stall_q <= slv_ar_valid_i & ~mst_ar_ready_i;
      r_stall_q  <= mst_r_valid_i  & ~slv_r_ready_i;
      aw_pl_q    <= slv_aw_i;
      w_pl_q     <= slv_w_i;
      b_pl_q     <= mst_b_i;
      ar_pl_q    <= slv_ar_i;
      r_pl_q     <= mst_r_i;

      if (push) begin
        fifo_mem[wr_ptr_q] <= aw_len;
        wr_ptr_q <= (wr_ptr_q == PW'(LEN_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(LEN_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      if (w_hs) beat_q <= w_last ? 8'd0 : beat_q + 8'd1;

      if (!proto_err_o && (err != '0)) begin
        proto_err_o <= 1'b1;
        err_code_o  <= err_code_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_bus_dv.sv
// Directed bench for axi_bus_dv: pass-through, handshake counters, outstanding tracking and error latch.
module tb_axi_bus_dv;

  localparam int unsigned AWW = 88;
  localparam int unsigned ARW = 82;
  localparam int unsigned WW  = 74;
  localparam int unsigned BW  = 7;
  localparam int unsigned RW  = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic           slv_aw_valid, slv_w_valid, slv_ar_valid, mst_b_valid, mst_r_valid;
  logic [AWW-1:0] slv_aw, mst_aw;
  logic [WW-1:0]  slv_w, mst_w;
  logic [ARW-1:0] slv_ar, mst_ar;
  logic [BW-1:0]  mst_b, slv_b;
  logic [RW-1:0]  mst_r, slv_r;
  logic           mst_aw_ready, mst_w_ready, mst_ar_ready, slv_b_ready, slv_r_ready;
  logic           slv_aw_ready, slv_w_ready, slv_ar_ready, mst_b_ready, mst_r_ready;
  logic           mst_aw_valid, mst_w_valid, mst_ar_valid, slv_b_valid, slv_r_valid;
  logic [31:0]    aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [15:0]    wr_outst, rd_outst;
  logic           proto_err;
  logic [3:0]     err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_bus_dv dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_i(slv_aw), .slv_aw_ready_o(slv_aw_ready),
    .slv_w_valid_i(slv_w_valid), .slv_w_i(slv_w), .slv_w_ready_o(slv_w_ready),
    .slv_ar_valid_i(slv_ar_valid), .slv_ar_i(slv_ar), .slv_ar_ready_o(slv_ar_ready),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_o(mst_aw), .mst_aw_ready_i(mst_aw_ready),
    .mst_w_valid_o(mst_w_valid), .mst_w_o(mst_w), .mst_w_ready_i(mst_w_ready),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_o(mst_ar), .mst_ar_ready_i(mst_ar_ready),
    .mst_b_valid_i(mst_b_valid), .mst_b_i(mst_b), .mst_b_ready_o(mst_b_ready),
    .mst_r_valid_i(mst_r_valid), .mst_r_i(mst_r), .mst_r_ready_o(mst_r_ready),
    .slv_b_valid_o(slv_b_valid), .slv_b_o(slv_b), .slv_b_ready_i(slv_b_ready),
    .slv_r_valid_o(slv_r_valid), .slv_r_o(slv_r), .slv_r_ready_i(slv_r_ready),
    .aw_cnt_o(aw_cnt), .w_cnt_o(w_cnt), .b_cnt_o(b_cnt), .ar_cnt_o(ar_cnt), .r_cnt_o(r_cnt),
    .wr_outst_o(wr_outst), .rd_outst_o(rd_outst),
    .proto_err_o(proto_err), .err_code_o(err_code)
  );

  function automatic logic [AWW-1:0] mk_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0};
  endfunction
  function automatic logic [ARW-1:0] mk_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
  endfunction
  function automatic logic [WW-1:0] mk_w(input logic [63:0] data, input logic last);
    return {data, 8'hFF, last, 1'b0};
  endfunction
  function automatic logic [BW-1:0] mk_b(input logic [3:0] id);
    return {id, 2'b00, 1'b0};
  endfunction
  function automatic logic [RW-1:0] mk_r(input logic [3:0] id, input logic [63:0] data, input logic last);
    return {id, data, 2'b00, last, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slv_aw_valid = 1'b0; slv_w_valid = 1'b0; slv_ar_valid = 1'b0;
    mst_b_valid  = 1'b0; mst_r_valid = 1'b0;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_ar_ready = 1'b1;
    slv_b_ready  = 1'b1; slv_r_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_aw_cnt"}, 128'(aw_cnt), 128'd0);
    check({tag, "_w_cnt"},  128'(w_cnt),  128'd0);
    check({tag, "_b_cnt"},  128'(b_cnt),  128'd0);
    check({tag, "_ar_cnt"}, 128'(ar_cnt), 128'd0);
    check({tag, "_r_cnt"},  128'(r_cnt),  128'd0);
    check({tag, "_wr_out"}, 128'(wr_outst), 128'd0);
    check({tag, "_rd_out"}, 128'(rd_outst), 128'd0);
    check({tag, "_perr"},   128'(proto_err), 128'd0);
    check({tag, "_code"},   128'(err_code), 128'd0);
  endtask

  initial begin
    slv_aw = '0; slv_w = '0; slv_ar = '0; mst_b = '0; mst_r = '0;
    do_reset();
    check_zero("reset");

    // Write burst len=3, then its response
    slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd1, 48'h100, 8'd3);
    #1;
    check("aw_pass", 128'(mst_aw), 128'(mk_aw(4'd1, 48'h100, 8'd3)));
    check("aw_vld_pass", 128'(mst_aw_valid), 128'd1);
    tick();
    slv_aw_valid = 1'b0;
    check("wr_aw_cnt", 128'(aw_cnt), 128'd1);
    check("wr_outst1", 128'(wr_outst), 128'd1);
    for (int i = 0; i < 4; i++) begin
      slv_w_valid = 1'b1; slv_w = mk_w(64'hA0 + 64'(i), (i == 3));
      #1;
      check("w_pass", 128'(mst_w), 128'(mk_w(64'hA0 + 64'(i), (i == 3))));
      tick();
    end
    slv_w_valid = 1'b0;
    check("wr_w_cnt", 128'(w_cnt), 128'd4);
    check("wr_perr", 128'(proto_err), 128'd0);
    mst_b_valid = 1'b1; mst_b = mk_b(4'd1);
    #1;
    check("b_pass", 128'(slv_b), 128'(mk_b(4'd1)));
    tick();
    mst_b_valid = 1'b0;
    check("wr_b_cnt", 128'(b_cnt), 128'd1);
    check("wr_outst0", 128'(wr_outst), 128'd0);
    check("wr_perr2", 128'(proto_err), 128'd0);

    // Read burst of two beats
    slv_ar_valid = 1'b1; slv_ar = mk_ar(4'd2, 48'h200, 8'd1);
    #1;
    check("ar_pass", 128'(mst_ar), 128'(mk_ar(4'd2, 48'h200, 8'd1)));
    tick();
    slv_ar_valid = 1'b0;
    check("rd_outst1", 128'(rd_outst), 128'd1);
    for (int i = 0; i < 2; i++) begin
      mst_r_valid = 1'b1; mst_r = mk_r(4'd2, 64'hDEAD_0000 + 64'(i), (i == 1));
      #1;
      check("r_pass", 128'(slv_r), 128'(mk_r(4'd2, 64'hDEAD_0000 + 64'(i), (i == 1))));
      check("r_vld_pass", 128'(slv_r_valid), 128'd1);
      tick();
    end
    mst_r_valid = 1'b0;
    check("rd_r_cnt", 128'(r_cnt), 128'd2);
    check("rd_outst0", 128'(rd_outst), 128'd0);
    check("rd_ar_cnt", 128'(ar_cnt), 128'd1);

    // Two AW handshakes, then AW and B in the same cycle
    slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd3, 48'h300, 8'd0);
    tick();
    tick();
    check("sim_outst2", 128'(wr_outst), 128'd2);
    mst_b_valid = 1'b1; mst_b = mk_b(4'd3);
    tick();
    slv_aw_valid = 1'b0; mst_b_valid = 1'b0;
    check("sim_outst", 128'(wr_outst), 128'd2);
    check("sim_aw_cnt", 128'(aw_cnt), 128'd4);
    check("sim_b_cnt", 128'(b_cnt), 128'd2);
    check("sim_perr", 128'(proto_err), 128'd0);

    // AW payload changes while stalled
    mst_aw_ready = 1'b0; slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd4, 48'h1000, 8'd0);
    #1;
    check("stall_rdy_pass", 128'(slv_aw_ready), 128'd0);
    tick();
    check("stall_perr0", 128'(proto_err), 128'd0);
    slv_aw = mk_aw(4'd4, 48'h2000, 8'd0);
    tick();
    check("stall_perr", 128'(proto_err), 128'd1);
    check("stall_code", 128'(err_code), 128'd1);
    mst_aw_ready = 1'b1;
    tick();
    slv_aw_valid = 1'b0;
    tick();
    check("stall_code_hold", 128'(err_code), 128'd1);
    check("stall_perr_hold", 128'(proto_err), 128'd1);
    check("stall_aw_cnt", 128'(aw_cnt), 128'd5);

    do_reset();
    check_zero("reset2");

    // Early WLAST, then an extra B with nothing outstanding
    slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd5, 48'h400, 8'd1);
    tick();
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w = mk_w(64'h55, 1'b1);
    tick();
    slv_w_valid = 1'b0;
    check("wlast_code", 128'(err_code), 128'd6);
    mst_b_valid = 1'b1; mst_b = mk_b(4'd5);
    tick();
    check("wlast_outst0", 128'(wr_outst), 128'd0);
    tick();
    mst_b_valid = 1'b0;
    check("wlast_code_hold", 128'(err_code), 128'd6);
    check("wlast_b_cnt", 128'(b_cnt), 128'd2);
    check("wlast_outst_sat", 128'(wr_outst), 128'd0);

    // Overflow of the length FIFO
    do_reset();
    slv_aw_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      slv_aw = mk_aw(4'd6, 48'h5000 + 48'(i * 16), 8'd2);
      tick();
      if (i == 7) check("ovf_perr8", 128'(proto_err), 128'd0);
    end
    slv_aw_valid = 1'b0;
    check("ovf_code", 128'(err_code), 128'd9);
    check("ovf_outst", 128'(wr_outst), 128'd9);
    check("ovf_aw_cnt", 128'(aw_cnt), 128'd9);
    do_reset();
    check_zero("reset3");

    // Stale FIFO head (len=2) must be gone after reset
    slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd7, 48'h600, 8'd0);
    tick();
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w = mk_w(64'h77, 1'b1);
    tick();
    slv_w_valid = 1'b0;
    check("fifo_clr_perr", 128'(proto_err), 128'd0);

    // R valid withdrawn while stalled
    slv_r_ready = 1'b0; mst_r_valid = 1'b1; mst_r = mk_r(4'd8, 64'h88, 1'b0);
    tick();
    mst_r_valid = 1'b0;
    tick();
    slv_r_ready = 1'b1;
    check("r_drop_code", 128'(err_code), 128'd5);

    // Simultaneous AW and W violations: lowest code wins
    do_reset();
    mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
    slv_aw_valid = 1'b1; slv_aw = mk_aw(4'd9, 48'h700, 8'd0);
    slv_w_valid = 1'b1; slv_w = mk_w(64'h99, 1'b1);
    tick();
    slv_aw_valid = 1'b0; slv_w_valid = 1'b0;
    tick();
    idle();
    check("prio_code", 128'(err_code), 128'd1);
    check("prio_perr", 128'(proto_err), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
